// File: rtl/priv_trap_sequencer_if.sv
// Redirect handshake between the trap sequencer and the hazard unit.
// master = sequencer, slave = hazard unit.
interface priv_trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            intr;
  logic            pipe_clear;
  logic            insert_pc;
  logic [XLEN-1:0] priv_pc;

  modport master (
    output intr,
    output insert_pc,
    output priv_pc,
    input  pipe_clear
  );

  modport slave (
    input  intr,
    input  insert_pc,
    input  priv_pc,
    output pipe_clear
  );
endinterface

// File: rtl/priv_trap_sequencer.sv
// Trap/return/wfi sequencer: prioritise, latch cause, flush, redirect.
// Optional vectored interrupt targets: define PRIV_TRAP_VECTORED_EN.
module priv_trap_sequencer #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               fault_insn,
  input  logic               mal_insn,
  input  logic               illegal_insn,
  input  logic               fault_l,
  input  logic               mal_l,
  input  logic               fault_s,
  input  logic               mal_s,
  input  logic               breakpoint,
  input  logic               env,
  input  logic               mret,
  input  logic               sret,
  input  logic               wfi,
  input  logic               timer_int,
  input  logic               soft_int,
  input  logic               ext_int,
  input  logic               mie_global,
  input  logic [XLEN-1:0]    epc,
  input  logic [XLEN-1:0]    badaddr,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_r,
  input  logic [XLEN-1:0]    sepc_r,
  priv_trap_sequencer_if.master pif,
  output logic               trap_commit,
  output logic [CAUSE_W-1:0] cause_o,
  output logic               cause_intr_o,
  output logic [XLEN-1:0]    epc_o,
  output logic [XLEN-1:0]    tval_o,
  output logic               wfi_stall
);

  typedef enum logic [2:0] {
    IDLE,
    TRAP_WAIT,
    TRAP_INS,
    RET_WAIT,
    RET_INS,
    WFI_SLEEP
  } state_t;

  state_t state, state_n;

  logic               exc;
  logic               exc_tv;
  logic [CAUSE_W-1:0] exc_cause;
  logic               irq;
  logic [CAUSE_W-1:0] irq_cause;
  logic               take_trap;
  logic               take_ret;
  logic [XLEN-1:0]    ret_pc;
  logic [XLEN-1:0]    trap_pc;
  logic               intr_c;
  logic               ins_c;
  logic [XLEN-1:0]    pc_c;

  // Fixed exception priority; exc_tv marks address-carrying causes.
  always_comb begin
    exc       = 1'b1;
    exc_tv    = 1'b1;
    exc_cause = '0;
    if (breakpoint) begin
      exc_cause = CAUSE_W'(3);
      exc_tv    = 1'b0;
    end else if (fault_insn) begin
      exc_cause = CAUSE_W'(1);
    end else if (mal_insn) begin
      exc_cause = CAUSE_W'(0);
    end else if (illegal_insn) begin
      exc_cause = CAUSE_W'(2);
      exc_tv    = 1'b0;
    end else if (env) begin
      exc_cause = CAUSE_W'(11);
      exc_tv    = 1'b0;
    end else if (mal_l) begin
      exc_cause = CAUSE_W'(4);
    end else if (mal_s) begin
      exc_cause = CAUSE_W'(6);
    end else if (fault_l) begin
      exc_cause = CAUSE_W'(5);
    end else if (fault_s) begin
      exc_cause = CAUSE_W'(7);
    end else begin
      exc    = 1'b0;
      exc_tv = 1'b0;
    end
  end

  always_comb begin
    irq = mie_global & (ext_int | soft_int | timer_int);
    if (ext_int)       irq_cause = CAUSE_W'(11);
    else if (soft_int) irq_cause = CAUSE_W'(3);
    else               irq_cause = CAUSE_W'(7);
  end

  always_comb begin
    trap_pc = {mtvec[XLEN-1:2], 2'b00};
`ifdef PRIV_TRAP_VECTORED_EN
    if (mtvec[1:0] == 2'b01 && cause_intr_o)
      trap_pc = trap_pc + (XLEN'(cause_o) << 2);
`endif
  end

  always_comb begin
    state_n     = state;
    take_trap   = 1'b0;
    take_ret    = 1'b0;
    intr_c      = 1'b0;
    ins_c       = 1'b0;
    pc_c        = '0;
    trap_commit = 1'b0;
    wfi_stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (exc || irq) begin
          take_trap = 1'b1;
          state_n   = TRAP_WAIT;
        end else if (mret || sret) begin
          take_ret = 1'b1;
          state_n  = RET_WAIT;
        end else if (wfi) begin
          state_n = WFI_SLEEP;
        end
      end
      TRAP_WAIT: begin
        intr_c = 1'b1;
        if (pif.pipe_clear) state_n = TRAP_INS;
      end
      TRAP_INS: begin
        intr_c      = 1'b1;
        ins_c       = 1'b1;
        trap_commit = 1'b1;
        pc_c        = trap_pc;
        state_n     = IDLE;
      end
      RET_WAIT: begin
        intr_c = 1'b1;
        if (pif.pipe_clear) state_n = RET_INS;
      end
      RET_INS: begin
        intr_c  = 1'b1;
        ins_c   = 1'b1;
        pc_c    = ret_pc;
        state_n = IDLE;
      end
      WFI_SLEEP: begin
        wfi_stall = 1'b1;
        if (timer_int || soft_int || ext_int) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pif.intr      = intr_c;
  assign pif.insert_pc = ins_c;
  assign pif.priv_pc   = pc_c;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      cause_o      <= '0;
      cause_intr_o <= 1'b0;
      epc_o        <= '0;
      tval_o       <= '0;
      ret_pc       <= '0;
    end else begin
      state <= state_n;
      if (take_trap) begin
        cause_o      <= exc ? exc_cause : irq_cause;
        cause_intr_o <= ~exc;
        epc_o        <= epc;
        tval_o       <= exc_tv ? badaddr : '0;
      end
      if (take_ret)
        ret_pc <= mret ? mepc_r : sepc_r;
    end
  end

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Directed bench for priv_trap_sequencer: vector table + corner sequences.
module tb_priv_trap_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l;
  logic        fault_s, mal_s, breakpoint, env;
  logic        mret, sret, wfi, timer_int, soft_int, ext_int, mie_global;
  logic [31:0] epc, badaddr, mtvec, mepc_r, sepc_r;
  logic        trap_commit, cause_intr_o, wfi_stall;
  logic [4:0]  cause_o;
  logic [31:0] epc_o, tval_o;

  priv_trap_sequencer_if #(.XLEN(32)) pif();

  priv_trap_sequencer #(.XLEN(32), .CAUSE_W(5)) dut (
    .CLK(CLK), .nRST(nRST),
    .fault_insn(fault_insn), .mal_insn(mal_insn),
    .illegal_insn(illegal_insn), .fault_l(fault_l), .mal_l(mal_l),
    .fault_s(fault_s), .mal_s(mal_s), .breakpoint(breakpoint),
    .env(env), .mret(mret), .sret(sret), .wfi(wfi),
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .mie_global(mie_global), .epc(epc), .badaddr(badaddr),
    .mtvec(mtvec), .mepc_r(mepc_r), .sepc_r(sepc_r),
    .pif(pif), .trap_commit(trap_commit), .cause_o(cause_o),
    .cause_intr_o(cause_intr_o), .epc_o(epc_o), .tval_o(tval_o),
    .wfi_stall(wfi_stall)
  );

  always #5 CLK = ~CLK;

`ifdef PRIV_TRAP_VECTORED_EN
  localparam logic [31:0] VEC_PC = 32'h0000_031C;
`else
  localparam logic [31:0] VEC_PC = 32'h0000_0300;
`endif

  // exc: {breakpoint,fault_insn,mal_insn,illegal,env,mal_l,mal_s,fault_l,fault_s}
  // irq: {ext,soft,timer}; kind: 0 none, 1 trap, 2 return
  typedef struct {
    logic [8:0]  exc;
    logic [2:0]  irq;
    logic        mie;
    logic        mr;
    logic        sr;
    logic [31:0] pc;
    logic [31:0] ba;
    logic [31:0] tv;
    logic [31:0] mepc;
    logic [31:0] sepc;
    int          kind;
    logic [31:0] e_pc;
    logic [4:0]  e_cause;
    logic        e_ci;
    logic [31:0] e_tval;
  } vec_t;

  vec_t vt[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      passed++;
  endtask

  task automatic clear_events();
    {breakpoint, fault_insn, mal_insn, illegal_insn, env,
     mal_l, mal_s, fault_l, fault_s} = '0;
    {ext_int, soft_int, timer_int} = '0;
    mret = 1'b0; sret = 1'b0; wfi = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic apply(input vec_t v, input int idx);
    string s;
    {breakpoint, fault_insn, mal_insn, illegal_insn, env,
     mal_l, mal_s, fault_l, fault_s} = v.exc;
    {ext_int, soft_int, timer_int} = v.irq;
    mie_global = v.mie; mret = v.mr; sret = v.sr;
    epc = v.pc; badaddr = v.ba; mtvec = v.tv;
    mepc_r = v.mepc; sepc_r = v.sepc;
    pif.pipe_clear = 1'b1;
    cyc();
    clear_events();
    s = $sformatf("v%0d", idx);
    chk({s, ".intr"}, 32'(pif.intr), 32'(v.kind != 0));
    cyc();
    chk({s, ".insert_pc"}, 32'(pif.insert_pc), 32'(v.kind != 0));
    if (v.kind != 0) begin
      chk({s, ".priv_pc"}, pif.priv_pc, v.e_pc);
      chk({s, ".trap_commit"}, 32'(trap_commit), 32'(v.kind == 1));
    end
    if (v.kind == 1) begin
      chk({s, ".cause"}, 32'(cause_o), 32'(v.e_cause));
      chk({s, ".cause_intr"}, 32'(cause_intr_o), 32'(v.e_ci));
      chk({s, ".epc_o"}, epc_o, v.pc);
      chk({s, ".tval"}, tval_o, v.e_tval);
    end
    cyc();
    chk({s, ".idle_ins"}, 32'(pif.insert_pc), 32'd0);
    chk({s, ".idle_intr"}, 32'(pif.intr), 32'd0);
  endtask

  initial begin
    vt.push_back('{9'b000100000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h104,
      32'h0, 32'h200, 32'h0, 32'h0, 1, 32'h200, 5'd2, 1'b0, 32'h0});
    vt.push_back('{9'b100000010, 3'b000, 1'b0, 1'b0, 1'b0, 32'h108,
      32'hDEAD_BEEF, 32'h200, 32'h0, 32'h0, 1, 32'h200, 5'd3, 1'b0, 32'h0});
    vt.push_back('{9'b000000010, 3'b000, 1'b0, 1'b0, 1'b0, 32'h10C,
      32'hDEAD_BEEF, 32'h200, 32'h0, 32'h0, 1, 32'h200, 5'd5, 1'b0,
      32'hDEAD_BEEF});
    vt.push_back('{9'b000000101, 3'b000, 1'b0, 1'b0, 1'b0, 32'h110,
      32'h0000_1234, 32'h203, 32'h0, 32'h0, 1, 32'h200, 5'd6, 1'b0,
      32'h0000_1234});
    vt.push_back('{9'b000011000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h114,
      32'h0000_5555, 32'h200, 32'h0, 32'h0, 1, 32'h200, 5'd11, 1'b0, 32'h0});
    vt.push_back('{9'b011000000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h118,
      32'h0000_0077, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 5'd1,
      1'b0, 32'h0000_0077});
    vt.push_back('{9'b000000000, 3'b101, 1'b1, 1'b0, 1'b0, 32'h11C,
      32'h0000_9999, 32'h300, 32'h0, 32'h0, 1, 32'h300, 5'd11, 1'b1, 32'h0});
    vt.push_back('{9'b000000000, 3'b011, 1'b1, 1'b0, 1'b0, 32'h120,
      32'h0, 32'h300, 32'h0, 32'h0, 1, 32'h300, 5'd3, 1'b1, 32'h0});
    vt.push_back('{9'b000000000, 3'b001, 1'b0, 1'b0, 1'b0, 32'h124,
      32'h0, 32'h300, 32'h0, 32'h0, 0, 32'h0, 5'd0, 1'b0, 32'h0});
    vt.push_back('{9'b000000000, 3'b001, 1'b0, 1'b1, 1'b0, 32'h128,
      32'h0, 32'h300, 32'h8000_0010, 32'h0, 2, 32'h8000_0010, 5'd0, 1'b0,
      32'h0});
    vt.push_back('{9'b000000000, 3'b000, 1'b0, 1'b0, 1'b1, 32'h12C,
      32'h0, 32'h300, 32'h0, 32'h1000, 2, 32'h1000, 5'd0, 1'b0, 32'h0});
    vt.push_back('{9'b000000000, 3'b000, 1'b0, 1'b1, 1'b1, 32'h130,
      32'h0, 32'h300, 32'h2222, 32'h3333, 2, 32'h2222, 5'd0, 1'b0, 32'h0});
    vt.push_back('{9'b000000001, 3'b000, 1'b0, 1'b1, 1'b0, 32'h134,
      32'h0000_0ABC, 32'h400, 32'h2222, 32'h0, 1, 32'h400, 5'd7, 1'b0,
      32'h0000_0ABC});
    vt.push_back('{9'b000000000, 3'b001, 1'b1, 1'b0, 1'b0, 32'h138,
      32'h0, 32'h301, 32'h0, 32'h0, 1, VEC_PC, 5'd7, 1'b1, 32'h0});

    clear_events();
    mie_global = 1'b0; pif.pipe_clear = 1'b1;
    epc = '0; badaddr = '0; mtvec = '0; mepc_r = '0; sepc_r = '0;
    nRST = 1'b0;
    cyc();
    chk("rst.intr", 32'(pif.intr), 32'd0);
    chk("rst.insert_pc", 32'(pif.insert_pc), 32'd0);
    chk("rst.cause", 32'(cause_o), 32'd0);
    chk("rst.epc_o", epc_o, 32'd0);
    chk("rst.wfi_stall", 32'(wfi_stall), 32'd0);
    nRST = 1'b1;
    cyc();

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Interrupt trap held off by pipe_clear=0; late events ignored.
    ext_int = 1'b1; timer_int = 1'b1; mie_global = 1'b1;
    mtvec = 32'h200; epc = 32'h500; pif.pipe_clear = 1'b0;
    cyc();
    clear_events();
    breakpoint = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d.intr", i), 32'(pif.intr), 32'd1);
      chk($sformatf("hold%0d.ins", i), 32'(pif.insert_pc), 32'd0);
      cyc();
    end
    breakpoint = 1'b0;
    chk("hold.cause", 32'(cause_o), 32'd11);
    chk("hold.cause_intr", 32'(cause_intr_o), 32'd1);
    pif.pipe_clear = 1'b1;
    cyc();
    chk("hold.ins", 32'(pif.insert_pc), 32'd1);
    chk("hold.priv_pc", pif.priv_pc, 32'h200);
    chk("hold.epc_o", epc_o, 32'h500);
    cyc();
    chk("hold.ins_once", 32'(pif.insert_pc), 32'd0);
    chk("hold.cause_kept", 32'(cause_o), 32'd11);

    // WFI sleep, woken by a masked soft interrupt.
    mie_global = 1'b0; wfi = 1'b1;
    cyc();
    wfi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wfi%0d.stall", i), 32'(wfi_stall), 32'd1);
      chk($sformatf("wfi%0d.ins", i), 32'(pif.insert_pc), 32'd0);
      if (i < 9) cyc();
    end
    soft_int = 1'b1;
    cyc();
    chk("wake.stall", 32'(wfi_stall), 32'd0);
    chk("wake.intr", 32'(pif.intr), 32'd0);
    cyc();
    soft_int = 1'b0;
    chk("wake.ins", 32'(pif.insert_pc), 32'd0);
    chk("wake.intr2", 32'(pif.intr), 32'd0);

    // Reset during TRAP_WAIT aborts the trap.
    illegal_insn = 1'b1; epc = 32'h700; pif.pipe_clear = 1'b0;
    cyc();
    clear_events();
    cyc();
    chk("abort.pre_intr", 32'(pif.intr), 32'd1);
    nRST = 1'b0;
    #1;
    chk("abort.intr", 32'(pif.intr), 32'd0);
    chk("abort.cause", 32'(cause_o), 32'd0);
    chk("abort.epc_o", epc_o, 32'd0);
    chk("abort.commit", 32'(trap_commit), 32'd0);
    cyc();
    nRST = 1'b1; pif.pipe_clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("abort%0d.ins", i), 32'(pif.insert_pc), 32'd0);
      chk($sformatf("abort%0d.intr", i), 32'(pif.intr), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
